red_pitaya_sys_initiator: RTL and testbench
===========================================

Name: red_pitaya_sys_initiator

Overview:
- System-bus initiator (master) for the classic sys_addr/sys_wdata/sys_wen/sys_ren/sys_rdata/sys_ack/sys_err register bus that the limiter, PID and lock blocks respond on.
- Accepts one register read/write request at a time over a valid/ready command port and issues a single-cycle bus strobe.
- Waits for ack/err or a timeout, then returns the read data and status over a valid/ready response port.
- Lets FPGA-internal sequencers (e.g. sweep or relock logic) reconfigure limiter rails and other registers without the PS.

Parameters:
- TIMEOUT_CYCLES, 255: number of WAIT cycles without ack/err before the transaction is aborted; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the timeout counter.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  command valid
- req_ready_o  out  1  command accepted when valid&ready
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  32  target byte address
- req_wdata_i  in  32  write data (ignored for reads)
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  32  captured sys_rdata (0 on write, error or timeout)
- rsp_err_o  out  1  responder signalled sys_err
- rsp_timeout_o  out  1  no ack/err within TIMEOUT_CYCLES
- sys_addr  out  32  bus address
- sys_wdata  out  32  bus write data
- sys_wen  out  1  write strobe
- sys_ren  out  1  read strobe
- sys_rdata  in  32  read data from responder
- sys_err  in  1  responder error
- sys_ack  in  1  responder acknowledge

Behaviour:
- Single clock clk_i; all state synchronous to it. Reset rst_i is synchronous, active-high.
- While rst_i is high, regardless of state, at the next edge:
  - state = IDLE.
  - req_ready_o = 0 during reset; it rises the cycle after reset deasserts.
  - sys_wen = sys_ren = 0; sys_addr = sys_wdata = 0.
  - rsp_valid_o, rsp_err_o, rsp_timeout_o = 0; rsp_rdata_o = 0.
  - Timeout counter = 0.
- All outputs are registered.
- FSM state IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o: latch addr, wdata and we; go to STROBE.
- FSM state STROBE (exactly 1 cycle):
  - sys_addr/sys_wdata hold the latched values.
  - sys_wen = we, sys_ren = ~we.
  - Counter cleared; go to WAIT.
- FSM state WAIT:
  - Strobes are 0; sys_addr/sys_wdata are held stable until the next command.
  - Sample sys_ack/sys_err each cycle, starting with the cycle after STROBE.
  - On sys_ack or sys_err:
    - rsp_err_o = sys_err.
    - rsp_rdata_o = sys_rdata if read & ~sys_err, else 0.
    - rsp_timeout_o = 0; go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 with no ack/err: rsp_timeout_o = 1, rsp_err_o = 0, rsp_rdata_o = 0; go to RESP.
- FSM state RESP:
  - rsp_valid_o = 1; response fields held stable.
  - On rsp_ready_i: go to IDLE and clear rsp_valid_o. A new command is accepted no earlier than the following cycle (no back-to-back overlap).
- Latency, with a responder that acks one cycle after the strobe:
  - Command accepted at edge k.
  - Strobe visible in cycle k+1.
  - Ack sampled at edge k+2.
  - rsp_valid_o high from cycle k+3.
  - Sustained throughput: one transaction per 4 cycles.
- Boundary conditions:
  - sys_ack and sys_err in the same cycle: the transaction completes with rsp_err_o = 1 and rsp_rdata_o = 0.
  - sys_ack/sys_err while in IDLE, STROBE or RESP (stale or late, e.g. after a timeout): ignored; no state change.
  - An ack arriving in the same WAIT cycle in which the counter would expire takes priority over the timeout.
  - req_valid_i while busy: req_ready_o = 0; the command is not consumed.
  - Request inputs may change freely while req_ready_o = 0.
  - rsp_ready_i held high continuously: each response lasts exactly 1 cycle.

Decomposition:
- Shared package red_pitaya_sys_pkg:
  - FSM state encoding (IDLE, STROBE, WAIT, RESP; 2 bits).
  - SYS_AW = 32, SYS_DW = 32.
  - Default TIMEOUT_CYCLES.
- One natural sub-module, red_pitaya_sys_watchdog: a clearable, enabled counter with a terminal-count pulse output (parameters CNT_W, TIMEOUT_CYCLES). It is reused by future initiators.

Test Plan:
- Write 0x0000_1FFF to address 0x4 with a limiter-style responder (ack one cycle later) -> sys_wen high for exactly 1 cycle with sys_addr = 0x4, sys_wdata = 0x1FFF; then rsp_valid_o at k+3 with rsp_err_o = 0, rsp_timeout_o = 0, rsp_rdata_o = 0.
- Read address 0x8 where the responder returns 0x0000_2000 -> sys_ren pulses for 1 cycle; rsp_rdata_o = 0x0000_2000; no error flags.
- Responder that never acks, TIMEOUT_CYCLES = 4 -> rsp_timeout_o = 1 and rsp_rdata_o = 0. A late ack injected 2 cycles after the response is ignored, and the next command completes normally.
- Responder asserting sys_ack and sys_err together on a read returning 0xDEAD_BEEF -> rsp_err_o = 1, rsp_rdata_o = 0.
- rsp_ready_i held low for 10 cycles while req_valid_i stays high -> rsp fields stable, req_ready_o = 0 throughout, exactly one strobe issued; the second command is accepted the cycle after RESP exits.
- rst_i asserted in the WAIT state, then an ack arrives 1 cycle later -> at the next edge all outputs are 0; the ack is ignored; req_ready_o = 1 the cycle after rst_i deasserts.

Source files
------------

// File: rtl/red_pitaya_sys_pkg.sv
// Shared types and constants for the red_pitaya system-bus initiator.
// Bus widths, FSM state encoding and the default response timeout.
package red_pitaya_sys_pkg;

   localparam int SYS_AW = 32;
   localparam int SYS_DW = 32;

   localparam int CNT_W_DEF = 8;
   localparam int TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STROBE = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } sys_state_e;

endpackage

// File: rtl/red_pitaya_sys_watchdog.sv
// Clearable, enabled cycle counter with a terminal-count pulse.
// tc_o is high while enabled in the cycle the count sits at its last value.
module red_pitaya_sys_watchdog #(
   parameter int CNT_W          = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;

   assign tc_o = en_i & (cnt_q == LAST);

   // Count enabled cycles; saturate at terminal count, clear on request.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt_q <= '0;
      end else if (en_i && !tc_o) begin
         cnt_q <= cnt_q + ONE;
      end
   end

endmodule

// File: rtl/red_pitaya_sys_initiator.sv
// System-bus initiator: one command in, one strobe out, one response back.
// Ack/err outside the WAIT state is ignored; a watchdog bounds the wait.
module red_pitaya_sys_initiator
   import red_pitaya_sys_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
   parameter int CNT_W          = CNT_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [SYS_AW-1:0] req_addr_i,
   input  logic [SYS_DW-1:0] req_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [SYS_DW-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              rsp_timeout_o,
   output logic [SYS_AW-1:0] sys_addr,
   output logic [SYS_DW-1:0] sys_wdata,
   output logic              sys_wen,
   output logic              sys_ren,
   input  logic [SYS_DW-1:0] sys_rdata,
   input  logic              sys_err,
   input  logic              sys_ack
);

   sys_state_e        state_q;
   logic              we_q;
   logic              req_ready_q;
   logic              rsp_valid_q;
   logic [SYS_DW-1:0] rsp_rdata_q;
   logic              rsp_err_q;
   logic              rsp_timeout_q;
   logic [SYS_AW-1:0] sys_addr_q;
   logic [SYS_DW-1:0] sys_wdata_q;
   logic              sys_wen_q;
   logic              sys_ren_q;

   logic              done;
   logic              wd_clr;
   logic              wd_en;
   logic              wd_tc;

   assign done   = sys_ack | sys_err;
   assign wd_clr = (state_q == ST_STROBE);
   assign wd_en  = (state_q == ST_WAIT) & ~done;

   red_pitaya_sys_watchdog #(
      .CNT_W          (CNT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (wd_clr),
      .en_i  (wd_en),
      .tc_o  (wd_tc)
   );

   // Transaction FSM; every output is a register updated here.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         we_q          <= 1'b0;
         req_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         sys_addr_q    <= '0;
         sys_wdata_q   <= '0;
         sys_wen_q     <= 1'b0;
         sys_ren_q     <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (req_valid_i && req_ready_q) begin
                  we_q        <= req_we_i;
                  sys_addr_q  <= req_addr_i;
                  sys_wdata_q <= req_wdata_i;
                  sys_wen_q   <= req_we_i;
                  sys_ren_q   <= ~req_we_i;
                  req_ready_q <= 1'b0;
                  state_q     <= ST_STROBE;
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            ST_STROBE: begin
               sys_wen_q <= 1'b0;
               sys_ren_q <= 1'b0;
               state_q   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (done) begin
                  rsp_err_q     <= sys_err;
                  rsp_timeout_q <= 1'b0;
                  rsp_rdata_q   <= (!we_q && !sys_err) ? sys_rdata : '0;
                  rsp_valid_q   <= 1'b1;
                  state_q       <= ST_RESP;
               end else if (wd_tc) begin
                  rsp_err_q     <= 1'b0;
                  rsp_timeout_q <= 1'b1;
                  rsp_rdata_q   <= '0;
                  rsp_valid_q   <= 1'b1;
                  state_q       <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready_o   = req_ready_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_rdata_o   = rsp_rdata_q;
   assign rsp_err_o     = rsp_err_q;
   assign rsp_timeout_o = rsp_timeout_q;
   assign sys_addr      = sys_addr_q;
   assign sys_wdata     = sys_wdata_q;
   assign sys_wen       = sys_wen_q;
   assign sys_ren       = sys_ren_q;

endmodule

// File: tb/tb_red_pitaya_sys_initiator.sv
// Directed bench for red_pitaya_sys_initiator with a 4-cycle timeout.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_red_pitaya_sys_initiator;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic [31:0] sys_addr;
   logic [31:0] sys_wdata;
   logic        sys_wen;
   logic        sys_ren;
   logic [31:0] sys_rdata;
   logic        sys_err;
   logic        sys_ack;

   int errors = 0;
   int checks = 0;
   int strobes;

   red_pitaya_sys_initiator #(
      .TIMEOUT_CYCLES (4),
      .CNT_W          (8)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_we_i      (req_we),
      .req_addr_i    (req_addr),
      .req_wdata_i   (req_wdata),
      .rsp_valid_o   (rsp_valid),
      .rsp_ready_i   (rsp_ready),
      .rsp_rdata_o   (rsp_rdata),
      .rsp_err_o     (rsp_err),
      .rsp_timeout_o (rsp_timeout),
      .sys_addr      (sys_addr),
      .sys_wdata     (sys_wdata),
      .sys_wen       (sys_wen),
      .sys_ren       (sys_ren),
      .sys_rdata     (sys_rdata),
      .sys_err       (sys_err),
      .sys_ack       (sys_ack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=hung expected=finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      sys_rdata = '0; sys_err = 1'b0; sys_ack = 1'b0;

      // reset state
      tick(); tick();
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_wen", {31'd0, sys_wen}, 32'd0);
      chk("rst_ren", {31'd0, sys_ren}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_addr", sys_addr, 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

      // write 0x1FFF to 0x4, ack one cycle after strobe
      req_valid = 1'b1; req_we = 1'b1;
      req_addr = 32'h4; req_wdata = 32'h1FFF;
      tick();
      req_valid = 1'b0;
      chk("wr_wen", {31'd0, sys_wen}, 32'd1);
      chk("wr_ren", {31'd0, sys_ren}, 32'd0);
      chk("wr_addr", sys_addr, 32'h4);
      chk("wr_wdata", sys_wdata, 32'h1FFF);
      chk("wr_busy", {31'd0, req_ready}, 32'd0);
      tick();
      chk("wr_wen_one_cycle", {31'd0, sys_wen}, 32'd0);
      chk("wr_no_early_rsp", {31'd0, rsp_valid}, 32'd0);
      sys_ack = 1'b1;
      tick();
      sys_ack = 1'b0;
      chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("wr_rsp_to", {31'd0, rsp_timeout}, 32'd0);
      chk("wr_rsp_rdata", rsp_rdata, 32'd0);
      rsp_ready = 1'b1;
      tick();
      chk("wr_rsp_done", {31'd0, rsp_valid}, 32'd0);
      chk("wr_idle_ready", {31'd0, req_ready}, 32'd1);

      // read 0x8 returning 0x2000
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8;
      tick();
      req_valid = 1'b0;
      chk("rd_ren", {31'd0, sys_ren}, 32'd1);
      chk("rd_wen", {31'd0, sys_wen}, 32'd0);
      chk("rd_addr", sys_addr, 32'h8);
      tick();
      chk("rd_ren_one_cycle", {31'd0, sys_ren}, 32'd0);
      sys_ack = 1'b1; sys_rdata = 32'h2000;
      tick();
      sys_ack = 1'b0; sys_rdata = 32'h0;
      chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rd_rdata", rsp_rdata, 32'h2000);
      chk("rd_err", {31'd0, rsp_err}, 32'd0);
      chk("rd_to", {31'd0, rsp_timeout}, 32'd0);
      tick();
      chk("rd_rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);

      // timeout: no ack for 4 WAIT cycles
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'hC;
      tick();
      req_valid = 1'b0;
      tick();
      tick(); tick(); tick();
      chk("to_not_yet", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("to_flag", {31'd0, rsp_timeout}, 32'd1);
      chk("to_err", {31'd0, rsp_err}, 32'd0);
      chk("to_rdata", rsp_rdata, 32'd0);
      tick();
      tick();
      sys_ack = 1'b1; sys_rdata = 32'h7777;
      tick();
      sys_ack = 1'b0; sys_rdata = 32'h0;
      chk("late_ack_ignored", {31'd0, rsp_valid}, 32'd0);
      chk("late_ack_ready", {31'd0, req_ready}, 32'd1);
      chk("late_ack_no_strobe", {30'd0, sys_wen, sys_ren}, 32'd0);
      req_valid = 1'b1; req_we = 1'b1;
      req_addr = 32'h10; req_wdata = 32'h5;
      tick();
      req_valid = 1'b0;
      chk("after_to_wen", {31'd0, sys_wen}, 32'd1);
      tick();
      sys_ack = 1'b1;
      tick();
      sys_ack = 1'b0;
      chk("after_to_valid", {31'd0, rsp_valid}, 32'd1);
      chk("after_to_flag", {31'd0, rsp_timeout}, 32'd0);
      tick();

      // ack on the last WAIT cycle beats the timeout
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
      tick();
      req_valid = 1'b0;
      tick();
      tick(); tick(); tick();
      sys_ack = 1'b1; sys_rdata = 32'h1234;
      tick();
      sys_ack = 1'b0; sys_rdata = 32'h0;
      chk("prio_valid", {31'd0, rsp_valid}, 32'd1);
      chk("prio_to", {31'd0, rsp_timeout}, 32'd0);
      chk("prio_rdata", rsp_rdata, 32'h1234);
      tick();

      // ack and err together on a read
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h50;
      tick();
      req_valid = 1'b0;
      tick();
      sys_ack = 1'b1; sys_err = 1'b1; sys_rdata = 32'hDEADBEEF;
      tick();
      sys_ack = 1'b0; sys_err = 1'b0; sys_rdata = 32'h0;
      chk("ackerr_valid", {31'd0, rsp_valid}, 32'd1);
      chk("ackerr_err", {31'd0, rsp_err}, 32'd1);
      chk("ackerr_rdata", rsp_rdata, 32'd0);
      chk("ackerr_to", {31'd0, rsp_timeout}, 32'd0);
      tick();

      // response back-pressure with a pending command
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b1;
      req_addr = 32'h20; req_wdata = 32'hAA;
      tick();
      strobes = int'(sys_wen);
      req_addr = 32'h24; req_wdata = 32'hBB;
      tick();
      strobes += int'(sys_wen);
      chk("bp_busy_wait", {31'd0, req_ready}, 32'd0);
      sys_ack = 1'b1;
      tick();
      sys_ack = 1'b0;
      for (int i = 0; i < 10; i++) begin
         strobes += int'(sys_wen);
         chk("bp_valid_hold", {31'd0, rsp_valid}, 32'd1);
         chk("bp_not_ready", {31'd0, req_ready}, 32'd0);
         chk("bp_addr_hold", sys_addr, 32'h20);
         chk("bp_err_hold", {30'd0, rsp_err, rsp_timeout}, 32'd0);
         tick();
      end
      chk("bp_one_strobe", strobes, 32'd1);
      rsp_ready = 1'b1;
      chk("bp_still_valid", {31'd0, rsp_valid}, 32'd1);
      tick();
      chk("bp_released", {31'd0, rsp_valid}, 32'd0);
      chk("bp_ready_again", {31'd0, req_ready}, 32'd1);
      chk("bp_no_strobe", {31'd0, sys_wen}, 32'd0);
      tick();
      req_valid = 1'b0;
      chk("bp_second_wen", {31'd0, sys_wen}, 32'd1);
      chk("bp_second_addr", sys_addr, 32'h24);
      chk("bp_second_wdata", sys_wdata, 32'hBB);
      tick();
      sys_ack = 1'b1;
      tick();
      sys_ack = 1'b0;
      chk("bp_second_rsp", {31'd0, rsp_valid}, 32'd1);
      tick();

      // reset while waiting, ack one cycle later is ignored
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h30;
      tick();
      req_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("wrst_ready", {31'd0, req_ready}, 32'd0);
      chk("wrst_addr", sys_addr, 32'd0);
      chk("wrst_strobes", {30'd0, sys_wen, sys_ren}, 32'd0);
      chk("wrst_valid", {31'd0, rsp_valid}, 32'd0);
      rst = 1'b0;
      sys_ack = 1'b1; sys_rdata = 32'h55;
      tick();
      sys_ack = 1'b0; sys_rdata = 32'h0;
      chk("wrst_ready_after", {31'd0, req_ready}, 32'd1);
      chk("wrst_ack_ignored", {31'd0, rsp_valid}, 32'd0);
      chk("wrst_rdata", rsp_rdata, 32'd0);
      tick();
      chk("wrst_still_idle", {31'd0, rsp_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
